// File: rtl/jb_mode_cntr_pkg.sv
// Shared types for the multi-mode counter: channel counting modes and the
// two-state ONE_SHOT sequencer.
package jb_cntr_pkg;

    typedef enum logic [1:0] {
        UP_WRAP   = 2'd0,
        DOWN_WRAP = 2'd1,
        UP_SAT    = 2'd2,
        ONE_SHOT  = 2'd3
    } cntr_mode_e;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } os_state_e;

endpackage

// File: rtl/jb_mode_cntr_if.sv
// Bundle of the per-channel control/data buses of jb_mode_cntr. The driver
// side (stimulus or host logic) uses master, the counter side uses slave.
interface jb_mode_cntr_if #(
    parameter int NUM_CH      = 4,
    parameter int COUNT_WIDTH = 39
);
    logic [NUM_CH-1:0]             enable;
    logic [NUM_CH-1:0]             clear;
    logic [NUM_CH-1:0]             load;
    logic [NUM_CH*COUNT_WIDTH-1:0] load_value;
    logic [NUM_CH*COUNT_WIDTH-1:0] max_value;
    logic [NUM_CH*2-1:0]           mode;
    logic [NUM_CH*COUNT_WIDTH-1:0] cntr;
    logic [NUM_CH-1:0]             tc;
    logic [NUM_CH-1:0]             done;

    modport master (
        output enable, clear, load, load_value, max_value, mode,
        input  cntr, tc, done
    );

    modport slave (
        input  enable, clear, load, load_value, max_value, mode,
        output cntr, tc, done
    );
endinterface

// File: rtl/jb_mode_cntr_ch.sv
// One counter channel: clear > load > count priority, four counting modes,
// ONE_SHOT sequencing via a RUN/DONE state. All outputs are registers.
module jb_mode_cntr_ch
    import jb_cntr_pkg::*;
#(
    parameter int COUNT_WIDTH = 39
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_value,
    input  logic [COUNT_WIDTH-1:0] max_value,
    input  logic [1:0]             mode,
    output logic [COUNT_WIDTH-1:0] cntr,
    output logic                   tc,
    output logic                   done
);
    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] cntr_reg;
    logic                   tc_reg;
    logic                   done_reg;
    os_state_e              state_reg;
    cntr_mode_e             mode_e;
    logic [COUNT_WIDTH-1:0] cntr_inc;
    logic [COUNT_WIDTH-1:0] cntr_dec;

    assign mode_e   = cntr_mode_e'(mode);
    assign cntr_inc = cntr_reg + ONE;
    assign cntr_dec = cntr_reg - ONE;

    // Channel state machine: counter, terminal-count pulse and ONE_SHOT state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cntr_reg  <= '0;
            tc_reg    <= 1'b0;
            done_reg  <= 1'b0;
            state_reg <= RUN;
        end else if (clear) begin
            cntr_reg  <= '0;
            tc_reg    <= 1'b0;
            done_reg  <= 1'b0;
            state_reg <= RUN;
        end else if (load) begin
            // A load above max_value is kept as-is; each mode resolves it on count.
            cntr_reg  <= load_value;
            tc_reg    <= 1'b0;
            done_reg  <= 1'b0;
            state_reg <= RUN;
        end else begin
            tc_reg <= 1'b0;
            // Leaving ONE_SHOT drops any completion status immediately.
            if (mode_e != ONE_SHOT) begin
                state_reg <= RUN;
                done_reg  <= 1'b0;
            end
            if (enable) begin
                case (mode_e)
                    UP_WRAP: begin
                        if (cntr_reg >= max_value) begin
                            cntr_reg <= '0;
                            tc_reg   <= 1'b1;
                        end else begin
                            cntr_reg <= cntr_inc;
                        end
                    end
                    DOWN_WRAP: begin
                        if (cntr_reg == '0 || cntr_reg > max_value) begin
                            cntr_reg <= max_value;
                            tc_reg   <= 1'b1;
                        end else begin
                            cntr_reg <= cntr_dec;
                        end
                    end
                    UP_SAT: begin
                        // cntr_inc cannot overflow here since cntr_reg < max_value.
                        if (cntr_reg < max_value) begin
                            cntr_reg <= cntr_inc;
                            tc_reg   <= (cntr_inc == max_value);
                        end
                    end
                    ONE_SHOT: begin
                        if (state_reg == RUN) begin
                            if (cntr_reg < max_value) begin
                                cntr_reg <= cntr_inc;
                                if (cntr_inc == max_value) begin
                                    state_reg <= DONE;
                                    tc_reg    <= 1'b1;
                                    done_reg  <= 1'b1;
                                end
                            end else begin
                                state_reg <= DONE;
                                tc_reg    <= 1'b1;
                                done_reg  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        cntr_reg <= cntr_reg;
                    end
                endcase
            end
        end
    end

    assign cntr = cntr_reg;
    assign tc   = tc_reg;
    assign done = done_reg;

endmodule

// File: rtl/jb_mode_cntr.sv
// Multi-channel, multi-mode counter: NUM_CH independent channels, bus slicing only.
module jb_mode_cntr
    import jb_cntr_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int COUNT_WIDTH = 39
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             enable,
    input  logic [NUM_CH-1:0]             clear,
    input  logic [NUM_CH-1:0]             load,
    input  logic [NUM_CH*COUNT_WIDTH-1:0] load_value,
    input  logic [NUM_CH*COUNT_WIDTH-1:0] max_value,
    input  logic [NUM_CH*2-1:0]           mode,
    output logic [NUM_CH*COUNT_WIDTH-1:0] cntr,
    output logic [NUM_CH-1:0]             tc,
    output logic [NUM_CH-1:0]             done
);
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        jb_mode_cntr_ch #(
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .enable     (enable[gi]),
            .clear      (clear[gi]),
            .load       (load[gi]),
            .load_value (load_value[gi*COUNT_WIDTH +: COUNT_WIDTH]),
            .max_value  (max_value[gi*COUNT_WIDTH +: COUNT_WIDTH]),
            .mode       (mode[gi*2 +: 2]),
            .cntr       (cntr[gi*COUNT_WIDTH +: COUNT_WIDTH]),
            .tc         (tc[gi]),
            .done       (done[gi])
        );
    end

endmodule
